ifu: RTL

Instruction fetch unit for the single-issue NPC core. It holds the program counter, issues one word-aligned read at a time to instruction memory, and presents each fetched 32-bit instruction with its PC to the instruction decode unit over a valid/ready handshake. Redirects from the execute stage (branches, jumps) discard any in-flight fetch and restart fetching at the new target. The block is the producer end of the instruction word the decoder consumes.

---
 rtl/ifu_if.sv | 46 ++++
 rtl/ifu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ifu_if.sv
// ifu_if
//   Bundles the instruction-fetch unit's bus signals. clk and rst_n stay
//   plain ports on the modules that use this interface.
//
//   master : the fetch unit (drives the memory request and the instruction
//            toward the decoder; receives memory responses, decoder ready
//            and execute-stage redirects)
//   slave  : the environment (instruction memory, decoder, execute stage)
//
//   imem_req_valid/ready/addr      read request channel (addr word aligned)
//   imem_rsp_valid/data/err        read response channel
//   inst_valid/ready/inst/pc/fault instruction channel to the decoder
//   redirect_valid/pc              one-cycle redirect pulse from execute
interface ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu.sv
// ifu - instruction fetch unit
//   Holds the PC and issues one word-aligned read at a time to instruction
//   memory. Each fetched word is presented to the decoder with its PC over a
//   valid/ready handshake. Redirects from execute discard any in-flight fetch
//   and restart at the new target.
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ifu_if.master (memory request/response, decoder channel,
//            redirect input)
//   RESET_PC : PC of the first fetch after reset
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, all outputs low; moves to REQ on the next edge
//   REQ   | request visible at req_addr, held until memory accepts it
//   WAIT  | request accepted, waiting for its single response
//   HOLD  | fetched instruction presented to the decoder
//
// All outputs are decoded from state and registers only, so no input has a
// combinational path to any output.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic  clk,
    input  logic  rst_n,
    ifu_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        kill, kill_nxt;
    logic        capture;
    logic [31:0] inst_q, inst_pc_q;
    logic        fault_q;
    logic [31:0] redirect_tgt;
    logic        unused_redirect_lsb;

    assign redirect_tgt        = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the next PC / kill / request address. req_addr is kept
    // separate from pc because a redirect while the request is visible must
    // not change the address already on the bus.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_nxt     = kill;
        req_addr_nxt = req_addr;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt    = REQ;
                req_addr_nxt = pc;
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    pc_nxt   = redirect_tgt;
                    kill_nxt = 1'b1;
                end
                if (bus.imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (kill || bus.redirect_valid) begin
                        // Stale response: drop it and refetch at the
                        // newest target.
                        state_nxt    = REQ;
                        kill_nxt     = 1'b0;
                        pc_nxt       = bus.redirect_valid ? redirect_tgt : pc;
                        req_addr_nxt = pc_nxt;
                    end else begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end
                end else if (bus.redirect_valid) begin
                    pc_nxt   = redirect_tgt;
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                // A redirect beats a concurrent decoder handshake.
                if (bus.redirect_valid) begin
                    state_nxt    = REQ;
                    pc_nxt       = redirect_tgt;
                    req_addr_nxt = redirect_tgt;
                end else if (bus.inst_ready) begin
                    state_nxt    = REQ;
                    pc_nxt       = pc + 32'd4;
                    req_addr_nxt = pc + 32'd4;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            kill      <= 1'b0;
            req_addr  <= 32'h0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            kill     <= kill_nxt;
            req_addr <= req_addr_nxt;
            if (capture) begin
                // A faulting fetch delivers a zero word.
                inst_q    <= bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
                inst_pc_q <= pc;
                fault_q   <= bus.imem_rsp_err;
            end
        end
    end

    always_comb begin
        bus.imem_req_valid = (state == REQ);
        bus.imem_req_addr  = (state == REQ) ? req_addr : 32'h0;
        bus.inst_valid     = (state == HOLD);
        bus.inst           = inst_q;
        bus.inst_pc        = inst_pc_q;
        bus.inst_fault     = fault_q;
    end

endmodule
